// File: rtl/imem_fetch_ctrl_if.sv
// ---------------------------------------------------------------------------
// imem_fetch_ctrl_if
// Groups every bus-level signal of the instruction-memory fetch controller.
//   load port : ld_valid, ld_data, ld_ready, load_start
//   IM port   : im_we, im_waddr, im_wdata, im_instr
//   core port : busPc, cpu_stall, br_taken, br_target, instr_out,
//               instr_valid, loading, load_done, load_err, pc_oob
// The master modport is the controller; the slave modport is the surrounding
// system (byte source, instruction memory and core).
// ---------------------------------------------------------------------------
interface imem_fetch_ctrl_if;
    logic        ld_valid;
    logic [7:0]  ld_data;
    logic        ld_ready;
    logic        load_start;

    logic        im_we;
    logic [8:0]  im_waddr;
    logic [31:0] im_wdata;
    logic [31:0] im_instr;

    logic [63:0] busPc;
    logic        cpu_stall;
    logic        br_taken;
    logic [63:0] br_target;
    logic [31:0] instr_out;
    logic        instr_valid;
    logic        loading;
    logic        load_done;
    logic        load_err;
    logic        pc_oob;

    modport master (
        input  ld_valid, ld_data, load_start, im_instr,
               cpu_stall, br_taken, br_target,
        output ld_ready, im_we, im_waddr, im_wdata, busPc, instr_out,
               instr_valid, loading, load_done, load_err, pc_oob
    );

    modport slave (
        output ld_valid, ld_data, load_start, im_instr,
               cpu_stall, br_taken, br_target,
        input  ld_ready, im_we, im_waddr, im_wdata, busPc, instr_out,
               instr_valid, loading, load_done, load_err, pc_oob
    );
endinterface

// File: rtl/imem_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// imem_fetch_ctrl
// Owns the instruction memory. After reset a boot loader takes a byte stream
// (16-bit little-endian word count, then little-endian 32-bit words) and
// writes one word per im_we pulse. It then releases the core and sequences
// the PC: sequential +4, stall hold, branch redirect, or reload request.
// Ports:
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : imem_fetch_ctrl_if.master (load port, IM port, core port)
// ---------------------------------------------------------------------------
module imem_fetch_ctrl #(
    parameter int unsigned WORDS = 512
) (
    input  logic              clk,
    input  logic              reset_n,
    imem_fetch_ctrl_if.master bus
);

    typedef enum logic [2:0] {
        S_HDR_LO,
        S_HDR_HI,
        S_LOAD,
        S_WRITE,
        S_RUN
    } state_t;

    state_t      r_state;
    logic [15:0] r_count;
    logic [8:0]  r_idx;
    logic [1:0]  r_bcnt;
    logic [23:0] r_asm;
    logic [63:0] r_pc;
    logic        r_ld_ready;
    logic        r_im_we;
    logic [8:0]  r_im_waddr;
    logic [31:0] r_im_wdata;
    logic        r_load_done;
    logic        r_load_err;

    logic        w_accept;
    logic [15:0] w_hdr_count;
    logic [15:0] w_idx_next;
    logic        w_hdr_bad;
    logic        w_run;
    logic        w_pc_oob;

    assign w_accept    = r_ld_ready & bus.ld_valid;
    assign w_hdr_count = {bus.ld_data, r_count[7:0]};
    assign w_idx_next  = {7'd0, r_idx} + 16'd1;
    assign w_hdr_bad   = (w_hdr_count == 16'd0) || (w_hdr_count > 16'(WORDS));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_HDR_LO;
            r_count     <= '0;
            r_idx       <= '0;
            r_bcnt      <= '0;
            r_asm       <= '0;
            r_pc        <= '0;
            r_ld_ready  <= 1'b0;
            r_im_we     <= 1'b0;
            r_im_waddr  <= '0;
            r_im_wdata  <= '0;
            r_load_done <= 1'b0;
            r_load_err  <= 1'b0;
        end else begin
            r_im_we     <= 1'b0;
            r_load_done <= 1'b0;
            case (r_state)
                S_HDR_LO: begin
                    r_ld_ready <= 1'b1;
                    if (w_accept) begin
                        r_count[7:0] <= bus.ld_data;
                        r_state      <= S_HDR_HI;
                    end
                end

                S_HDR_HI: begin
                    r_ld_ready <= 1'b1;
                    if (w_accept) begin
                        r_count <= w_hdr_count;
                        if (w_hdr_bad) begin
                            r_load_err <= 1'b1;
                            r_state    <= S_HDR_LO;
                        end else begin
                            r_load_err <= 1'b0;
                            r_idx      <= '0;
                            r_bcnt     <= '0;
                            r_state    <= S_LOAD;
                        end
                    end
                end

                S_LOAD: begin
                    if (w_accept) begin
                        if (r_bcnt == 2'd3) begin
                            // Write strobe, address and data are registered here
                            // so they appear exactly during the WRITE cycle.
                            r_im_we     <= 1'b1;
                            r_im_waddr  <= r_idx;
                            r_im_wdata  <= {bus.ld_data, r_asm};
                            r_load_done <= (w_idx_next == r_count);
                            r_ld_ready  <= 1'b0;
                            r_bcnt      <= '0;
                            r_state     <= S_WRITE;
                        end else begin
                            case (r_bcnt)
                                2'd0:    r_asm[7:0]   <= bus.ld_data;
                                2'd1:    r_asm[15:8]  <= bus.ld_data;
                                default: r_asm[23:16] <= bus.ld_data;
                            endcase
                            r_bcnt <= r_bcnt + 2'd1;
                        end
                    end
                end

                S_WRITE: begin
                    if (w_idx_next == r_count) begin
                        r_pc    <= '0;
                        r_state <= S_RUN;
                    end else begin
                        r_idx      <= r_idx + 9'd1;
                        r_ld_ready <= 1'b1;
                        r_state    <= S_LOAD;
                    end
                end

                S_RUN: begin
                    if (bus.load_start) begin
                        r_pc       <= '0;
                        r_ld_ready <= 1'b1;
                        r_state    <= S_HDR_LO;
                    end else if (bus.br_taken) begin
                        r_pc <= {bus.br_target[63:2], 2'b00};
                    end else if (!bus.cpu_stall) begin
                        r_pc <= r_pc + 64'd4;
                    end
                end

                default: begin
                    r_ld_ready <= 1'b0;
                    r_state    <= S_HDR_LO;
                end
            endcase
        end
    end

    // Bounds and validity follow the registered PC combinationally, giving
    // zero-cycle fetch latency against the IM's combinational read port.
    assign w_run    = (r_state == S_RUN);
    assign w_pc_oob = w_run && ((r_pc[63:11] != '0) || ({7'd0, r_pc[10:2]} >= r_count));

    assign bus.ld_ready    = r_ld_ready;
    assign bus.im_we       = r_im_we;
    assign bus.im_waddr    = r_im_waddr;
    assign bus.im_wdata    = r_im_wdata;
    assign bus.busPc       = r_pc;
    assign bus.instr_out   = bus.im_instr;
    assign bus.instr_valid = w_run && !w_pc_oob;
    assign bus.pc_oob      = w_pc_oob;
    assign bus.loading     = !w_run;
    assign bus.load_done   = r_load_done;
    assign bus.load_err    = r_load_err;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_imem_fetch_ctrl
// Directed bench for imem_fetch_ctrl: boot load, fetch sequencing from a
// vector table, bad headers, bubbled reload and reset during a load.
// ---------------------------------------------------------------------------
module tb_imem_fetch_ctrl;

    logic clk;
    logic reset_n;

    imem_fetch_ctrl_if bus();

    imem_fetch_ctrl #(.WORDS(512)) u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    // Instruction memory model, written from the observed write pulses.
    logic [31:0] tb_mem [512];
    assign bus.im_instr = tb_mem[bus.busPc[10:2]];

    typedef struct {
        logic        done;
        logic [8:0]  addr;
        logic [31:0] data;
    } wr_t;
    wr_t wq[$];

    typedef struct {
        logic        stall;
        logic        br;
        logic [63:0] tgt;
        logic [63:0] pc;
        logic        valid;
        logic [31:0] instr;
    } run_vec_t;

    localparam int NV = 16;
    run_vec_t tbl [NV];

    logic [31:0] prog [3];
    logic [7:0]  prog_bytes [14];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (reset_n && bus.im_we) begin
            wq.push_back('{done: bus.load_done, addr: bus.im_waddr, data: bus.im_wdata});
            tb_mem[bus.im_waddr] = bus.im_wdata;
            chk("ld_ready_in_write", {63'd0, bus.ld_ready}, 64'd0);
        end
    end

    task automatic send_byte(input logic [7:0] b, input int unsigned gap);
        logic acc;
        bit   ok;
        ok = 1'b0;
        for (int unsigned g = 0; g < gap; g++) begin
            bus.ld_valid = 1'b0;
            step();
        end
        bus.ld_valid = 1'b1;
        bus.ld_data  = b;
        for (int k = 0; k < 16; k++) begin
            acc = bus.ld_ready;
            step();
            if (acc) begin
                ok = 1'b1;
                break;
            end
        end
        bus.ld_valid = 1'b0;
        if (!ok) begin
            n_total++;
            n_bad++;
            $display("FAIL byte_accept_timeout: byte %0h not accepted, expected acceptance within 16 cycles", b);
        end
    endtask

    task automatic check_prog_writes(input string tag);
        chk({tag, "_nwrites"}, 64'(wq.size()), 64'd3);
        for (int i = 0; i < 3 && i < wq.size(); i++) begin
            chk({tag, "_waddr"}, 64'(wq[i].addr), 64'(i));
            chk({tag, "_wdata"}, 64'(wq[i].data), 64'(prog[i]));
            chk({tag, "_wdone"}, 64'(wq[i].done), (i == 2) ? 64'd1 : 64'd0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected normal finish");
        $fatal(1, "watchdog");
    end

    initial begin
        prog[0] = 32'hF84002A0;
        prog[1] = 32'hF84002A1;
        prog[2] = 32'hF8004387;
        prog_bytes = '{8'h03, 8'h00,
                       8'hA0, 8'h02, 8'h40, 8'hF8,
                       8'hA1, 8'h02, 8'h40, 8'hF8,
                       8'h87, 8'h43, 8'h00, 8'hF8};

        //               stall br    target                  pc                      valid instr
        tbl[0]  = '{1'b0, 1'b0, 64'd0,                  64'd4,                  1'b1, 32'hF84002A1};
        tbl[1]  = '{1'b1, 1'b0, 64'd0,                  64'd4,                  1'b1, 32'hF84002A1};
        tbl[2]  = '{1'b1, 1'b0, 64'd0,                  64'd4,                  1'b1, 32'hF84002A1};
        tbl[3]  = '{1'b0, 1'b0, 64'd0,                  64'd8,                  1'b1, 32'hF8004387};
        tbl[4]  = '{1'b0, 1'b1, 64'd0,                  64'd0,                  1'b1, 32'hF84002A0};
        tbl[5]  = '{1'b0, 1'b0, 64'd0,                  64'd4,                  1'b1, 32'hF84002A1};
        tbl[6]  = '{1'b0, 1'b0, 64'd0,                  64'd8,                  1'b1, 32'hF8004387};
        tbl[7]  = '{1'b0, 1'b0, 64'd0,                  64'd12,                 1'b0, 32'h0};
        tbl[8]  = '{1'b0, 1'b0, 64'd0,                  64'd16,                 1'b0, 32'h0};
        tbl[9]  = '{1'b0, 1'b1, 64'h6,                  64'd4,                  1'b1, 32'hF84002A1};
        tbl[10] = '{1'b1, 1'b1, 64'h3,                  64'd0,                  1'b1, 32'hF84002A0};
        tbl[11] = '{1'b1, 1'b0, 64'd0,                  64'd0,                  1'b1, 32'hF84002A0};
        tbl[12] = '{1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 32'h0};
        tbl[13] = '{1'b0, 1'b0, 64'd0,                  64'd0,                  1'b1, 32'hF84002A0};
        tbl[14] = '{1'b0, 1'b1, 64'h800,                64'h800,                1'b0, 32'h0};
        tbl[15] = '{1'b0, 1'b1, 64'h9,                  64'd8,                  1'b1, 32'hF8004387};

        for (int i = 0; i < 512; i++) tb_mem[i] = '0;

        reset_n        = 1'b0;
        bus.ld_valid   = 1'b0;
        bus.ld_data    = '0;
        bus.load_start = 1'b0;
        bus.cpu_stall  = 1'b0;
        bus.br_taken   = 1'b0;
        bus.br_target  = '0;

        // Reset values
        step();
        step();
        chk("rst_im_we",       {63'd0, bus.im_we},       64'd0);
        chk("rst_im_waddr",    64'(bus.im_waddr),        64'd0);
        chk("rst_im_wdata",    64'(bus.im_wdata),        64'd0);
        chk("rst_load_done",   {63'd0, bus.load_done},   64'd0);
        chk("rst_load_err",    {63'd0, bus.load_err},    64'd0);
        chk("rst_instr_valid", {63'd0, bus.instr_valid}, 64'd0);
        chk("rst_pc_oob",      {63'd0, bus.pc_oob},      64'd0);
        chk("rst_loading",     {63'd0, bus.loading},     64'd1);
        chk("rst_ld_ready",    {63'd0, bus.ld_ready},    64'd0);
        chk("rst_busPc",       bus.busPc,                64'd0);

        reset_n = 1'b1;
        step();
        chk("post_rst_ld_ready", {63'd0, bus.ld_ready}, 64'd1);

        // Program load without gaps
        wq.delete();
        for (int i = 0; i < 14; i++) send_byte(prog_bytes[i], 0);
        chk("last_write_we",   {63'd0, bus.im_we},     64'd1);
        chk("last_write_done", {63'd0, bus.load_done}, 64'd1);
        chk("last_write_load", {63'd0, bus.loading},   64'd1);
        step();
        check_prog_writes("load1");
        chk("run0_pc",      bus.busPc,                64'd0);
        chk("run0_valid",   {63'd0, bus.instr_valid}, 64'd1);
        chk("run0_loading", {63'd0, bus.loading},     64'd0);
        chk("run0_done",    {63'd0, bus.load_done},   64'd0);
        chk("run0_instr",   64'(bus.instr_out),       64'(prog[0]));

        // Fetch sequencing vectors
        for (int i = 0; i < NV; i++) begin
            bus.cpu_stall = tbl[i].stall;
            bus.br_taken  = tbl[i].br;
            bus.br_target = tbl[i].tgt;
            step();
            chk($sformatf("vec%0d_pc", i),    bus.busPc,                tbl[i].pc);
            chk($sformatf("vec%0d_valid", i), {63'd0, bus.instr_valid}, {63'd0, tbl[i].valid});
            chk($sformatf("vec%0d_oob", i),   {63'd0, bus.pc_oob},      {63'd0, ~tbl[i].valid});
            if (tbl[i].valid)
                chk($sformatf("vec%0d_instr", i), 64'(bus.instr_out), 64'(tbl[i].instr));
        end

        // Reload request beats a simultaneous branch
        bus.cpu_stall  = 1'b0;
        bus.br_taken   = 1'b1;
        bus.br_target  = 64'h40;
        bus.load_start = 1'b1;
        step();
        bus.br_taken   = 1'b0;
        bus.load_start = 1'b0;
        chk("reload_loading",  {63'd0, bus.loading},     64'd1);
        chk("reload_pc",       bus.busPc,                64'd0);
        chk("reload_valid",    {63'd0, bus.instr_valid}, 64'd0);
        chk("reload_ld_ready", {63'd0, bus.ld_ready},    64'd1);

        // Bad headers
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        chk("hdr0_err",     {63'd0, bus.load_err}, 64'd1);
        chk("hdr0_loading", {63'd0, bus.loading},  64'd1);
        send_byte(8'h01, 0);
        send_byte(8'h02, 0);
        chk("hdr513_err",   {63'd0, bus.load_err}, 64'd1);

        // Valid header with bubbles, then the same program
        wq.delete();
        for (int i = 0; i < 14; i++) begin
            send_byte(prog_bytes[i], $urandom_range(0, 3));
            if (i == 1) chk("hdr_ok_err", {63'd0, bus.load_err}, 64'd0);
        end
        chk("bub_last_done", {63'd0, bus.load_done}, 64'd1);
        step();
        check_prog_writes("bubble");
        chk("bub_run_pc",    bus.busPc,                64'd0);
        chk("bub_run_valid", {63'd0, bus.instr_valid}, 64'd1);

        // Reset in the middle of a load
        bus.load_start = 1'b1;
        step();
        bus.load_start = 1'b0;
        for (int i = 0; i < 6; i++) send_byte(prog_bytes[i], 0);
        chk("mid_we_before_rst", {63'd0, bus.im_we}, 64'd1);
        #1;
        reset_n = 1'b0;
        #1;
        chk("midrst_im_we",       {63'd0, bus.im_we},       64'd0);
        chk("midrst_im_waddr",    64'(bus.im_waddr),        64'd0);
        chk("midrst_im_wdata",    64'(bus.im_wdata),        64'd0);
        chk("midrst_load_done",   {63'd0, bus.load_done},   64'd0);
        chk("midrst_instr_valid", {63'd0, bus.instr_valid}, 64'd0);
        chk("midrst_pc_oob",      {63'd0, bus.pc_oob},      64'd0);
        chk("midrst_loading",     {63'd0, bus.loading},     64'd1);
        chk("midrst_ld_ready",    {63'd0, bus.ld_ready},    64'd0);
        step();
        reset_n = 1'b1;

        wq.delete();
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        send_byte(8'h33, 0);
        send_byte(8'h44, 1);
        chk("one_done", {63'd0, bus.load_done}, 64'd1);
        step();
        chk("one_nwrites", 64'(wq.size()), 64'd1);
        if (wq.size() > 0) begin
            chk("one_waddr", 64'(wq[0].addr), 64'd0);
            chk("one_wdata", 64'(wq[0].data), 64'h44332211);
        end
        chk("one_pc",    bus.busPc,                64'd0);
        chk("one_valid", {63'd0, bus.instr_valid}, 64'd1);
        chk("one_instr", 64'(bus.instr_out),       64'h44332211);
        step();
        chk("one_pc4",   bus.busPc,                64'd4);
        chk("one_oob4",  {63'd0, bus.pc_oob},      64'd1);
        chk("one_inv4",  {63'd0, bus.instr_valid}, 64'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/imem_fetch_ctrl.md
# imem_fetch_ctrl

Controller that owns the 512 × 32 instruction memory. After reset it runs a boot loader that receives a program as a byte stream and writes it into the IM, one word per write pulse. It then releases the core and sequences fetch: it holds the PC, drives `busPc` into the IM's combinational read port, and advances on sequential, stall and branch requests. It sits between the external load port, the instruction memory and the core's fetch/decode stage.

## Interface
- `WORDS`, 512: IM depth in words; word index is `busPc[10:2]`.
- `clk`  in  1: single clock, rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `ld_valid`  in  1: load byte valid.
- `ld_data`  in  8: load byte.
- `ld_ready`  out  1: controller accepts the byte; transfer occurs when `ld_valid & ld_ready`.
- `load_start`  in  1: single-cycle request to reload; honoured only in RUN.
- `im_we`  out  1: IM write strobe.
- `im_waddr`  out  9: IM write word index.
- `im_wdata`  out  32: IM write data.
- `im_instr`  in  32: IM read data at `busPc[10:2]` (combinational).
- `busPc`  out  64: program counter, drives the IM read address.
- `cpu_stall`  in  1: hold the PC.
- `br_taken`  in  1: redirect the PC to `br_target`.
- `br_target`  in  64: branch target byte address.
- `instr_out`  out  32: instruction to decode, equal to `im_instr`.
- `instr_valid`  out  1: `instr_out` is a fetched in-range instruction.
- `loading`  out  1: high in any load state.
- `load_done`  out  1: one-cycle pulse when the last word is written.
- `load_err`  out  1: sticky bad-header flag.
- `pc_oob`  out  1: PC is outside the loaded program.

## Operation
- States:
  - HDR_LO: accept header byte 0, count[7:0].
  - HDR_HI: accept header byte 1, count[15:8].
  - LOAD: accept word bytes, little-endian; byte 0 lands in bits [7:0].
  - WRITE: one-cycle IM write.
  - RUN: fetch.
- Header check on HDR_HI acceptance:
  - count = 0 or count > WORDS → `load_err` = 1, return to HDR_LO.
  - Otherwise → `load_err` = 0, clear the word index, go to LOAD.
- LOAD: the 4th byte of a word moves the state to WRITE. In WRITE, `im_we` = 1, `im_waddr` = word index, `im_wdata` = assembled word.
- After WRITE:
  - Index + 1 = count → pulse `load_done`, PC = 0, go to RUN.
  - Otherwise increment the index and return to LOAD.
- `ld_ready` = 1 in HDR_LO, HDR_HI and LOAD; 0 in WRITE and RUN. Gaps in `ld_valid` are allowed anywhere and only delay the sequence.
- Next PC in RUN, priority high to low:
  1. `load_start`: PC = 0, go to HDR_LO.
  2. `br_taken`: PC = {`br_target[63:2]`, 2'b00}. Low bits are ignored.
  3. `cpu_stall`: PC holds.
  4. Otherwise: PC + 4, 64-bit wrap.
- `pc_oob` = RUN & (`busPc[63:11]` ≠ 0 | `busPc[10:2]` ≥ count). The PC still advances when out of bounds; the core is expected to branch back.
- `instr_valid` = RUN & !`pc_oob`. `instr_out` = `im_instr` in every state.
- `loading` = state ≠ RUN.
- `load_start` is ignored outside RUN. `br_taken` and `cpu_stall` are ignored outside RUN.

## Timing
- Reset (asynchronous assert, synchronous release): state HDR_LO, PC = 0, count = 0, index = 0, byte counter = 0.
  - Outputs in reset: `im_we`, `im_waddr`, `im_wdata`, `load_done`, `load_err`, `instr_valid`, `pc_oob` = 0; `loading` = 1.
  - `ld_ready` = 0 while `reset_n` is low; 1 from the first clock after release.
- Per word: minimum 5 cycles (4 accept cycles + 1 WRITE cycle). `im_we` is asserted in the cycle after the 4th byte is accepted.
- `load_done` is high in the WRITE cycle of the last word. RUN starts on the next cycle with `busPc` = 0 and `instr_valid` = 1 in that same cycle.
- Fetch timing: `busPc` updates on the clock edge; `instr_out`/`instr_valid` are valid combinationally in the same cycle. There is zero-cycle fetch latency, and each redirect takes effect one cycle after it is requested.
- Reset mid-load: the partial program is abandoned. The next header restarts loading at index 0.

## Test plan
- Program load and run:
  - Stimulus: header 03 00, then bytes A0 02 40 F8, A1 02 40 F8, 87 43 00 F8.
  - Required: `im_we` pulses at indices 0/1/2 with data F84002A0/F84002A1/F8004387; `load_done` coincides with the 3rd pulse.
  - Then `busPc` reads 0, 4, 8 with `instr_valid` = 1. At 12, `pc_oob` = 1 and `instr_valid` = 0.
- Stall: `cpu_stall` high for 2 cycles at `busPc` = 4 → `busPc` stays 4 for 3 cycles, then 8.
- Branch:
  - At `busPc` = 8, `br_taken` with target 0 → next `busPc` = 0.
  - Target 0x6 → `busPc` = 4.
  - `br_taken` together with `cpu_stall` → branch taken.
- Bad header:
  - Header 00 00 → `load_err` = 1, state remains HDR_LO.
  - Header 01 02 (513) → `load_err` = 1.
  - A following valid header 01 00 → `load_err` = 0.
- Bubbles and reload:
  - Random `ld_valid` gaps → same writes as the first scenario; `ld_ready` = 0 in every WRITE cycle.
  - `load_start` in RUN together with `br_taken` → next cycle `loading` = 1, `busPc` = 0.
- Reset mid-load: assert `reset_n` low after 6 bytes → all outputs at their reset values immediately. A new 1-word load then writes index 0.
